dw_conv3x3_window: RTL and testbench

//  Downstream consumer of the 3-row line buffer. Takes the per-column vertical taps
//  (top, middle, bottom), builds a 3x3 sliding window with horizontal shift registers,
//  and computes one depthwise 3x3 convolution output per window.
//  The datapath is a fixed-latency, non-stalling pipeline: MAC, bias, round, saturate, optional ReLU.

---
 rtl/dw_conv3x3_window.sv | 140 ++++++++++++++
 tb/tb_dw_conv3x3_window.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dw_conv3x3_window.sv
// Depthwise 3x3 convolution over a sliding window built from three vertical taps.
// Fixed 3-cycle pipeline: product, bias-accumulate, round/saturate/ReLU.

module dw_conv3x3_tap #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   pix,
    input  logic signed [DATA_WIDTH-1:0]   wgt,
    output logic signed [2*DATA_WIDTH-1:0] prod
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prod <= '0;
        else     prod <= pix * wgt;
    end
endmodule

module dw_conv3x3_window #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IMG_WIDTH  = 64,
    parameter bit USE_RELU   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] row0,
    input  logic [DATA_WIDTH-1:0] row1,
    input  logic [DATA_WIDTH-1:0] row2,
    input  logic                  valid_in,
    input  logic                  w_wr_en,
    input  logic [3:0]            w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out,
    output logic                  last_out
);
    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + 4;
    localparam int STAGES = 4;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    logic [COL_W-1:0]                  col;
    logic [2:0][DATA_WIDTH-1:0]        taps;
    logic [2:0][2:0][DATA_WIDTH-1:0]   win;
    logic [8:0][DATA_WIDTH-1:0]        wgt;
    logic signed [DATA_WIDTH-1:0]      bias;
    logic [STAGES:1]                   vld_pipe;
    logic [STAGES:1]                   last_pipe;
    logic signed [PROD_W-1:0]          prod [9];
    logic signed [ACC_W-1:0]           acc, acc_next;
    logic signed [ACC_W:0]             rnd, shifted;
    logic [DATA_WIDTH-1:0]             res;
    logic                              accept;
    logic                              at_last;

    assign taps    = {row2, row1, row0};
    assign accept  = valid_in && (col >= COL_W'(2));
    assign at_last = (col == LAST_COL);

    // Address 10..15 writes are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wgt  <= '0;
            bias <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < 9; i++)
                if (w_addr == 4'(i)) wgt[i] <= w_data;
            if (w_addr == 4'd9) bias <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            win <= '0;
        end else if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= taps[r];
            end
            col <= at_last ? '0 : col + COL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
            last_pipe <= {last_pipe[STAGES-1:1], at_last};
        end
    end

    // Tap i sits at row i/3, column i%3, matching weight address 3*r+c.
    for (genvar i = 0; i < 9; i++) begin : g_tap
        dw_conv3x3_tap #(.DATA_WIDTH(DATA_WIDTH)) u_tap (
            .clk  (clk),
            .rst  (rst),
            .pix  (win[i / 3][i % 3]),
            .wgt  (wgt[i]),
            .prod (prod[i])
        );
    end

    always_comb begin
        acc_next = ACC_W'(bias) <<< FRAC_BITS;
        for (int i = 0; i < 9; i++)
            acc_next = acc_next + ACC_W'(prod[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else     acc <= acc_next;
    end

    always_comb begin
        rnd     = {acc[ACC_W-1], acc} + RND;
        shifted = rnd >>> FRAC_BITS;
        if (shifted > SAT_MAX)      res = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) res = SAT_MIN[DATA_WIDTH-1:0];
        else                        res = shifted[DATA_WIDTH-1:0];
        if (USE_RELU && res[DATA_WIDTH-1]) res = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      pixel_out <= '0;
        else if (vld_pipe[STAGES-1])  pixel_out <= res;
    end

    assign valid_out = vld_pipe[STAGES];
    assign last_out  = vld_pipe[STAGES] & last_pipe[STAGES];

endmodule

// File: tb/tb_dw_conv3x3_window.sv
// Directed bench: two instances (ReLU on / off) share stimulus; outputs are
// captured on the falling edge and compared against hand-computed values.

module tb_dw_conv3x3_window;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] row0 = '0, row1 = '0, row2 = '0;
    logic        valid_in = 1'b0;
    logic        w_wr_en = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic [15:0] pixel_out_a, pixel_out_b;
    logic        valid_out_a, valid_out_b, last_out_a, last_out_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int col_m = 0;
    int stray_last = 0;

    int obs_a[$], obs_b[$], obs_cyc[$], obs_last[$];
    int exp_a[$], exp_b[$], exp_cyc[$], exp_last[$];

    dw_conv3x3_window #(.USE_RELU(1'b1)) u_relu (
        .clk(clk), .rst(rst), .row0(row0), .row1(row1), .row2(row2),
        .valid_in(valid_in), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .pixel_out(pixel_out_a), .valid_out(valid_out_a), .last_out(last_out_a)
    );

    dw_conv3x3_window #(.USE_RELU(1'b0)) u_lin (
        .clk(clk), .rst(rst), .row0(row0), .row1(row1), .row2(row2),
        .valid_in(valid_in), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .pixel_out(pixel_out_b), .valid_out(valid_out_b), .last_out(last_out_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out_a) begin
            obs_a.push_back(int'(pixel_out_a));
            obs_b.push_back(int'(pixel_out_b));
            obs_cyc.push_back(cyc);
            obs_last.push_back(int'(last_out_a));
        end
        if ((last_out_a && !valid_out_a) || (valid_out_a != valid_out_b)) stray_last <= stray_last + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        w_wr_en = 1'b1; w_addr = a; w_data = d;
        step();
        w_wr_en = 1'b0;
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < 9; i++) wr(4'(i), w);
        wr(4'd9, b);
        wr(4'd12, 16'h1234);
    endtask

    // One beat (or idle cycle); queues the hand-computed result for col>=2 beats.
    task automatic drive(input logic v, input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] t2, input int ea, input int eb);
        valid_in = v; row0 = t0; row1 = t1; row2 = t2;
        if (v) begin
            if (col_m >= 2) begin
                exp_a.push_back(ea);
                exp_b.push_back(eb);
                exp_cyc.push_back(cyc + 4);
                exp_last.push_back(col_m == 63 ? 1 : 0);
            end
            col_m = (col_m == 63) ? 0 : col_m + 1;
        end
        step();
        valid_in = 1'b0;
    endtask

    task automatic run_row(input logic [15:0] t, input int ea, input int eb, input bit gap);
        for (int c = 0; c < 64; c++) begin
            drive(1'b1, t, t, t, ea, eb);
            if (gap) drive(1'b0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 0, 0);
        end
    endtask

    task automatic clear_q();
        obs_a.delete(); obs_b.delete(); obs_cyc.delete(); obs_last.delete();
        exp_a.delete(); exp_b.delete(); exp_cyc.delete(); exp_last.delete();
    endtask

    task automatic check_stream(input string tag);
        int n;
        repeat (6) step();
        chk($sformatf("%s_count", tag), obs_a.size(), exp_a.size());
        n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_relu%0d", tag, i), obs_a[i], exp_a[i]);
            chk($sformatf("%s_lin%0d", tag, i), obs_b[i], exp_b[i]);
            chk($sformatf("%s_lat%0d", tag, i), obs_cyc[i], exp_cyc[i]);
            chk($sformatf("%s_last%0d", tag, i), obs_last[i], exp_last[i]);
        end
        clear_q();
    endtask

    initial begin
        #2;
        chk("rst_pixel", int'(pixel_out_a), 0);
        chk("rst_valid", int'(valid_out_a), 0);
        chk("rst_last", int'(last_out_a), 0);
        step(); step();
        rst = 1'b0;
        step();

        // 1.0 weights, constant 1.0 taps: 9.0 everywhere
        load(16'h0100, 16'h0000);
        run_row(16'h0100, 'h0900, 'h0900, 1'b0);
        check_stream("t1");

        run_row(16'h0100, 'h0900, 'h0900, 1'b1);
        check_stream("t2_gap");

        // -1.0 weights: -9.0, clamped by ReLU
        load(16'hFF00, 16'h0000);
        run_row(16'h0100, 'h0000, 'hF700, 1'b0);
        check_stream("t3_neg");

        load(16'h0100, 16'h0000);
        run_row(16'h6400, 'h7FFF, 'h7FFF, 1'b0);
        check_stream("t4_satp");
        run_row(16'h9C00, 'h0000, 'h8000, 1'b0);
        check_stream("t4_satn");

        // Centre weight only, bias 0.5, ramp on the middle row
        load(16'h0000, 16'h0080);
        wr(4'd4, 16'h0100);
        for (int c = 0; c < 64; c++) begin
            int e;
            e = (c - 1) * 'h100 + 'h80;
            drive(1'b1, 16'h7777, 16'(c * 'h100), 16'h8888, e, e);
        end
        check_stream("t5_ramp");

        // Reset mid-row with results in flight
        for (int c = 0; c < 20; c++)
            drive(1'b1, 16'h7777, 16'(c * 'h100), 16'h8888, 0, 0);
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", int'(valid_out_a), 0);
        chk("t6_pixel_clr", int'(pixel_out_a), 0);
        step();
        rst = 1'b0;
        clear_q();
        col_m = 0;
        wr(4'd4, 16'h0100);
        wr(4'd9, 16'h0080);
        repeat (4) step();
        chk("t6_inflight_dropped", obs_a.size(), 0);
        for (int c = 0; c < 3; c++)
            drive(1'b1, 16'h7777, 16'(c * 'h100), 16'h8888, 'h0180, 'h0180);
        check_stream("t6_restart");

        chk("stray_last_or_valid", stray_last, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
